ifns_decode_arbiter: RTL and testbench

Shares one combinational IFNS 30-bit-to-21-bit decoder core (decoderIFNS_21di_core) between N_LANES codeword requesters, for example receive groups of a crosstalk-avoidance TSV bus.
- Round-robin arbitration selects one lane per cycle.
- The chosen codeword is decoded and registered into a single output stage with a valid/ready handshake.
- The output is tagged with the source lane index.

---
 rtl/ifns_pkg.sv | 7 +
 rtl/decoderIFNS_21di_core.sv | 28 ++
 rtl/ifns_rr_arbiter.sv | 20 ++
 rtl/ifns_decode_arbiter.sv | 76 +++++++
 tb/tb_ifns_decode_arbiter.sv | 119 +++++++++++
 5 files changed

// File: rtl/ifns_pkg.sv
// ifns_pkg: shared widths and types for the IFNS decode arbiter slice.
package ifns_pkg;
  localparam int IFNS_CW_W = 30;
  localparam int IFNS_DATA_W = 21;
  typedef logic [IFNS_CW_W-1:0] ifns_cw_t;
  typedef logic [IFNS_DATA_W-1:0] ifns_val_t;
endpackage

// File: rtl/decoderIFNS_21di_core.sv
// decoderIFNS_21di_core: combinational IFNS decoder, d_k weighs F(k) for k<30 and d30 weighs F(31).
module decoderIFNS_21di_core (
  input  logic d1, d2, d3, d4, d5, d6, d7, d8, d9, d10,
  input  logic d11, d12, d13, d14, d15, d16, d17, d18, d19, d20,
  input  logic d21, d22, d23, d24, d25, d26, d27, d28, d29, d30,
  output logic [20:0] q
);
  logic [29:0] d;
  logic [20:0] acc, a, b, t;
  assign d = {d30, d29, d28, d27, d26, d25, d24, d23, d22, d21,
              d20, d19, d18, d17, d16, d15, d14, d13, d12, d11,
              d10, d9, d8, d7, d6, d5, d4, d3, d2, d1};
  // a walks F(1)..F(29); after the loop b holds F(31); the sum wraps at 2^21
  always_comb begin
    acc = '0;
    a = 21'd1;
    b = 21'd1;
    t = '0;
    for (int k = 0; k < 29; k++) begin
      acc = acc + (d[k] ? a : 21'd0);
      t = a + b;
      a = b;
      b = t;
    end
    acc = acc + (d[29] ? b : 21'd0);
  end
  assign q = acc;
endmodule

// File: rtl/ifns_rr_arbiter.sv
// ifns_rr_arbiter: one-hot round-robin grant, searching from ptr upward modulo N.
module ifns_rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] grant
);
  // descending scan so the lane closest to ptr is written last and wins
  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--)
      if (en && req[(int'(ptr) + i) % N]) begin
        grant = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
      end
  end
endmodule

// File: rtl/ifns_decode_arbiter.sv
// ifns_decode_arbiter: round-robin sharing of one IFNS decoder with a registered valid/ready output.
// Optional per-lane saturating grant counters on stat_cnt when IFNS_ARB_STATS_EN is defined.
module ifns_decode_arbiter
  import ifns_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int CW_W = IFNS_CW_W,
  parameter int DATA_W = IFNS_DATA_W,
  parameter int LANE_W = $clog2(N_LANES)
) (
`ifdef IFNS_ARB_STATS_EN
  output logic [N_LANES*16-1:0]   stat_cnt,
`endif
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_LANES-1:0]      req_valid,
  input  logic [N_LANES*CW_W-1:0] req_cw,
  output logic [N_LANES-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [LANE_W-1:0]       out_lane
);
  logic              out_valid_q;
  ifns_val_t         out_data_q, dec;
  logic [LANE_W-1:0] out_lane_q, rr_ptr_q, gidx;
  logic [N_LANES-1:0] grant;
  ifns_cw_t          sel_cw;
  ifns_rr_arbiter #(.N(N_LANES), .W(LANE_W)) u_arb (
    .req(req_valid), .ptr(rr_ptr_q), .en(!rst && (!out_valid_q || out_ready)), .grant(grant)
  );
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_LANES; i++)
      if (grant[i]) gidx = LANE_W'(i);
  end
  assign sel_cw = req_cw[gidx*CW_W +: CW_W];
  decoderIFNS_21di_core u_core (
    .d1(sel_cw[0]),   .d2(sel_cw[1]),   .d3(sel_cw[2]),   .d4(sel_cw[3]),   .d5(sel_cw[4]),
    .d6(sel_cw[5]),   .d7(sel_cw[6]),   .d8(sel_cw[7]),   .d9(sel_cw[8]),   .d10(sel_cw[9]),
    .d11(sel_cw[10]), .d12(sel_cw[11]), .d13(sel_cw[12]), .d14(sel_cw[13]), .d15(sel_cw[14]),
    .d16(sel_cw[15]), .d17(sel_cw[16]), .d18(sel_cw[17]), .d19(sel_cw[18]), .d20(sel_cw[19]),
    .d21(sel_cw[20]), .d22(sel_cw[21]), .d23(sel_cw[22]), .d24(sel_cw[23]), .d25(sel_cw[24]),
    .d26(sel_cw[25]), .d27(sel_cw[26]), .d28(sel_cw[27]), .d29(sel_cw[28]), .d30(sel_cw[29]),
    .q(dec)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      rr_ptr_q    <= '0;
    end else if (|grant) begin
      out_valid_q <= 1'b1;
      out_data_q  <= dec;
      out_lane_q  <= gidx;
      rr_ptr_q    <= (gidx == LANE_W'(N_LANES - 1)) ? '0 : gidx + 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
  assign req_ready = grant;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
`ifdef IFNS_ARB_STATS_EN
  for (genvar i = 0; i < N_LANES; i++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else if (grant[i] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign stat_cnt[i*16 +: 16] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_ifns_decode_arbiter.sv
// tb_ifns_decode_arbiter: scoreboard bench with a Fibonacci-weight reference decoder and round-robin model.
module tb_ifns_decode_arbiter;
  localparam int N = 4, CW = 30, DW = 21, LW = 2;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*CW-1:0] req_cw = '0;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_lane;
`ifdef IFNS_ARB_STATS_EN
  logic [N*16-1:0] stat_cnt;
`endif
  always #5 clk = ~clk;
  ifns_decode_arbiter #(.N_LANES(N)) dut (
`ifdef IFNS_ARB_STATS_EN
    .stat_cnt(stat_cnt),
`endif
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cw(req_cw), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane)
  );
  typedef struct packed {logic [LW-1:0] lane; logic [DW-1:0] data;} exp_t;
  exp_t sb[$];
  int checks = 0, passes = 0, ptr_m = 0;
  int fib[32];
  int grants[N];
  bit can_m, was_rst;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic logic [DW-1:0] ref_decode(input logic [CW-1:0] cw);
    longint s = 0;
    for (int k = 1; k <= 30; k++) if (cw[k-1]) s += (k == 30) ? fib[31] : fib[k];
    return DW'(s % 2097152);
  endfunction
  function automatic logic [N*CW-1:0] rand_cw();
    logic [N*CW-1:0] c;
    for (int i = 0; i < N; i++) c[i*CW +: CW] = CW'($urandom);
    return c;
  endfunction
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N*CW-1:0] cw, input logic rdy);
    int g;
    @(negedge clk);
    #1;
    if (was_rst) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_lane", out_lane, 0);
    end
    rst = r; req_valid = v; req_cw = cw; out_ready = rdy;
    can_m = (sb.size() == 0) || rdy;
    #2;
    g = -1;
    if (!r && can_m)
      for (int i = 0; i < N; i++)
        if (g < 0 && v[(ptr_m + i) % N]) g = (ptr_m + i) % N;
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    if (r) begin
      sb.delete();
      ptr_m = 0;
      for (int i = 0; i < N; i++) grants[i] = 0;
    end else if (g >= 0) begin
      sb.push_back('{lane: LW'(g), data: ref_decode(cw[g*CW +: CW])});
      ptr_m = (g + 1) % N;
      if (grants[g] < 65535) grants[g]++;
    end
    was_rst = r;
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("out_valid", out_valid, sb.size() > 0);
      if (out_valid && sb.size() > 0) begin
        chk("out_lane", out_lane, sb[0].lane);
        chk("out_data", out_data, sb[0].data);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end
  initial begin
    logic [N*CW-1:0] c;
    logic [CW-1:0] wv[4];
    fib[0] = 0; fib[1] = 1;
    for (int k = 2; k < 32; k++) fib[k] = fib[k-1] + fib[k-2];
    for (int i = 0; i < N; i++) grants[i] = 0;
    cycle(1, '0, '0, 0);
    cycle(1, 4'hF, rand_cw(), 1);
    c = rand_cw(); c[2*CW +: CW] = 30'h1;
    cycle(0, 4'b0100, c, 1);
    cycle(0, '0, rand_cw(), 1);
    wv[0] = 30'h20000000; wv[1] = 30'h81; wv[2] = 30'h18000000; wv[3] = 30'h3FFFFFFF;
    for (int j = 0; j < 4; j++) begin
      c = rand_cw(); c[2*CW +: CW] = wv[j];
      cycle(0, 4'b0100, c, 1);
    end
    cycle(0, '0, '0, 1);
    for (int j = 0; j < 9; j++) cycle(0, 4'hF, rand_cw(), 1);
    cycle(0, '0, '0, 1);
    cycle(0, 4'b0001, rand_cw(), 1);
    for (int j = 0; j < 5; j++) cycle(0, 4'b0011, rand_cw(), 0);
    for (int j = 0; j < 3; j++) cycle(0, 4'b0011, rand_cw(), 1);
    cycle(0, 4'hF, rand_cw(), 0);
    cycle(1, 4'hF, rand_cw(), 0);
    cycle(0, 4'hF, rand_cw(), 1);
    for (int j = 0; j < 500; j++)
      cycle($urandom_range(0, 99) == 0, N'($urandom), rand_cw(), $urandom_range(0, 3) != 0);
    for (int j = 0; j < 4; j++) cycle(0, '0, rand_cw(), 1);
`ifdef IFNS_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_cnt", stat_cnt[i*16 +: 16], grants[i]);
`endif
    @(negedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
